// File: rtl/timer_responder.sv
// DIV/TIMA/TMA/TAC timer on the CPU bus with delayed TMA reload and a one-clock IRQ pulse.
// Define TIMER_GLITCH_EN to let DIV/TAC writes cause the spurious TIMA tick seen on DMG hardware.
module timer_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] mem_addr,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  mem_data_out,
    output logic        mem_select,
    output logic        timer_irq
);

    typedef enum logic [1:0] {
        IDLE,
        OVF,
        RELOAD
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        in_prev_q, in_prev_d;
    logic        irq_q, irq_d;

    logic [15:0] offset;
    logic        wr_en, wr_div, wr_tima, wr_tma, wr_tac;
    logic        in_now, tick;

    // Tap order is {bit7, bit5, bit3, bit9} so TAC[1:0] indexes it directly.
    function automatic logic tick_in(input logic [3:0] taps, input logic [2:0] tac);
        return taps[tac[1:0]] && tac[2];
    endfunction

    // Unsigned wrap makes the range test safe even for a base near 16'hFFFF.
    assign offset     = mem_addr - BASE_ADDR;
    assign mem_select = mem_enable && (offset < 16'd4);

    assign wr_en   = mem_select && mem_write && (t_cycle == 2'd3);
    assign wr_div  = wr_en && (offset[1:0] == 2'd0);
    assign wr_tima = wr_en && (offset[1:0] == 2'd1);
    assign wr_tma  = wr_en && (offset[1:0] == 2'd2);
    assign wr_tac  = wr_en && (offset[1:0] == 2'd3);

    assign in_now = tick_in({div_q[7], div_q[5], div_q[3], div_q[9]}, tac_q);
    assign tick   = in_prev_q && !in_now;

    always_comb begin
        mem_data_out = 8'hFF;
        if (mem_select) begin
            case (offset[1:0])
                2'd0:    mem_data_out = div_q[15:8];
                2'd1:    mem_data_out = tima_q;
                2'd2:    mem_data_out = tma_q;
                default: mem_data_out = {5'b11111, tac_q};
            endcase
        end
    end

    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    always_comb begin
        div_d   = wr_div ? 16'd0 : div_q + 16'd1;
        tma_d   = wr_tma ? mem_data_in : tma_q;
        tac_d   = wr_tac ? mem_data_in[2:0] : tac_q;
        tima_d  = tima_q;
        state_d = state_q;
        cnt_d   = cnt_q + 2'd1;
        irq_d   = 1'b0;

`ifdef TIMER_GLITCH_EN
        in_prev_d = in_now;
`else
        // Re-seed the edge detector from post-write values so a DIV/TAC write cannot fake a falling edge.
        in_prev_d = (wr_div || wr_tac)
                  ? tick_in({div_d[7], div_d[5], div_d[3], div_d[9]}, tac_d)
                  : in_now;
`endif

        case (state_q)
            IDLE: begin
                if (wr_tima) begin
                    tima_d = mem_data_in;
                end else if (tick) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = OVF;
                        cnt_d   = 2'd0;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_d  = mem_data_in;
                    state_d = IDLE;
                end else if (cnt_q == 2'd3) begin
                    tima_d  = tma_d;
                    irq_d   = 1'b1;
                    state_d = RELOAD;
                    cnt_d   = 2'd0;
                end
            end
            RELOAD: begin
                // TIMA follows TMA (including a same-edge TMA write); CPU TIMA writes and ticks are dropped.
                tima_d = tma_d;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= 16'd0;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'd0;
            cnt_q     <= 2'd0;
            in_prev_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            cnt_q     <= cnt_d;
            in_prev_q <= in_prev_d;
            irq_q     <= irq_d;
        end
    end

    assign timer_irq = irq_q;

endmodule

// File: tb/tb_timer_responder.sv
// Self-checking bench for timer_responder: bus reads are scoreboarded against constant expectations.
// Honors TIMER_GLITCH_EN for the DIV-write glitch expectation.
module tb_timer_responder;

    localparam logic [15:0] DIV_A  = 16'hFF04;
    localparam logic [15:0] TIMA_A = 16'hFF05;
    localparam logic [15:0] TMA_A  = 16'hFF06;
    localparam logic [15:0] TAC_A  = 16'hFF07;

`ifdef TIMER_GLITCH_EN
    localparam logic [7:0] GLITCH_TIMA = 8'h41;
`else
    localparam logic [7:0] GLITCH_TIMA = 8'h40;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  t_cycle;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_select;
    logic        timer_irq;

    timer_responder dut (
        .clk          (clk),
        .reset        (reset),
        .t_cycle      (t_cycle),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_select   (mem_select),
        .timer_irq    (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       irq;
        logic       sel;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, commit on the following rising edge, release just after it.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input logic [1:0] tc = 2'd3);
        @(negedge clk);
        mem_addr    = addr;
        mem_data_in = data;
        mem_enable  = 1'b1;
        mem_write   = 1'b1;
        t_cycle     = tc;
        @(posedge clk);
        #1;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        t_cycle    = 2'd0;
    endtask

    task automatic expect_read(input string tag, input logic [15:0] addr, input logic [7:0] data,
                               input logic irq, input logic sel = 1'b1);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.irq  = irq;
        e.sel  = sel;
        sb_q.push_back(e);
        @(negedge clk);
        mem_addr   = addr;
        mem_enable = 1'b1;
        mem_write  = 1'b0;
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_data"}, {8'h00, mem_data_out}, {8'h00, e.data});
        check({e.tag, "_irq"},  {15'd0, timer_irq},    {15'd0, e.irq});
        check({e.tag, "_sel"},  {15'd0, mem_select},   {15'd0, e.sel});
        mem_enable = 1'b0;
    endtask

    // Leaves TIMA=FF, TMA=F0, TAC=101 with div_cnt restarted; returns just after the edge into div state 16.
    task automatic arm_overflow();
        bus_write(TAC_A, 8'h00);
        bus_write(TMA_A, 8'hF0);
        bus_write(TIMA_A, 8'hFF);
        bus_write(DIV_A, 8'h00);
        bus_write(TAC_A, 8'h05);
        repeat (15) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ovf_data [6] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        logic       ovf_irq  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset       = 1'b1;
        t_cycle     = 2'd0;
        mem_addr    = 16'h0000;
        mem_enable  = 1'b0;
        mem_write   = 1'b0;
        mem_data_in = 8'h00;

        repeat (3) @(posedge clk);
        expect_read("rst_div",  DIV_A,  8'h00, 1'b0);
        expect_read("rst_tima", TIMA_A, 8'h00, 1'b0);
        expect_read("rst_tma",  TMA_A,  8'h00, 1'b0);
        expect_read("rst_tac",  TAC_A,  8'hF8, 1'b0);
        reset = 1'b0;

        // Divider: 512 clocks after reset DIV reads 02.
        repeat (512) @(posedge clk);
        expect_read("div_512", DIV_A, 8'h02, 1'b0);

        // DIV write clears the count and suppresses that edge's increment.
        bus_write(DIV_A, 8'h5A);
        expect_read("div_clr", DIV_A, 8'h00, 1'b0);
        repeat (255) @(posedge clk);
        expect_read("div_255", DIV_A, 8'h00, 1'b0);
        expect_read("div_256", DIV_A, 8'h01, 1'b0);

        // Writes outside t_cycle 3 are ignored.
        bus_write(TMA_A, 8'hAB, 2'd2);
        expect_read("tc_tma", TMA_A, 8'h00, 1'b0);
        bus_write(TAC_A, 8'h07, 2'd1);
        expect_read("tc_tac", TAC_A, 8'hF8, 1'b0);

        // Fastest rate: ticks land on div states 17, 33, ..., the tenth at 161.
        bus_write(DIV_A, 8'h00);
        bus_write(TIMA_A, 8'h00);
        bus_write(TAC_A, 8'h05);
        repeat (158) @(posedge clk);
        expect_read("fast_9",  TIMA_A, 8'h09, 1'b0);
        expect_read("fast_10", TIMA_A, 8'h0A, 1'b0);

        // Overflow: four clocks of 00, then F0 with a single IRQ clock.
        arm_overflow();
        for (int i = 0; i < 6; i++) begin
            expect_read($sformatf("ovf_%0d", i), TIMA_A, ovf_data[i], ovf_irq[i]);
        end

        // RELOAD window: TIMA write ignored, TMA write tracked.
        bus_write(TIMA_A, 8'h77);
        expect_read("rel_tima_wr", TIMA_A, 8'hF0, 1'b0);
        bus_write(TMA_A, 8'h12);
        expect_read("rel_tma_wr", TIMA_A, 8'h12, 1'b0);

        // Write during OVF cancels the reload and the IRQ.
        arm_overflow();
        expect_read("ovfw_pre", TIMA_A, 8'hFF, 1'b0);
        expect_read("ovfw_ovf", TIMA_A, 8'h00, 1'b0);
        bus_write(TIMA_A, 8'h33);
        for (int i = 0; i < 4; i++) begin
            expect_read($sformatf("ovfw_%0d", i), TIMA_A, 8'h33, 1'b0);
        end

        // Glitch: DIV write while the bit-9 tap is high.
        bus_write(TAC_A, 8'h00);
        bus_write(DIV_A, 8'h00);
        bus_write(TIMA_A, 8'h40);
        bus_write(TAC_A, 8'h04);
        repeat (600) @(posedge clk);
        expect_read("glitch_pre", TIMA_A, 8'h40, 1'b0);
        bus_write(DIV_A, 8'h00);
        expect_read("glitch_a", TIMA_A, GLITCH_TIMA, 1'b0);
        expect_read("glitch_b", TIMA_A, GLITCH_TIMA, 1'b0);

        // Address boundaries.
        expect_read("tac_ff07",     TAC_A,     8'hFC, 1'b0);
        expect_read("unmapped_ff08", 16'hFF08, 8'hFF, 1'b0, 1'b0);
        expect_read("unmapped_ff03", 16'hFF03, 8'hFF, 1'b0, 1'b0);

        // Reset mid-OVF: no reload, no IRQ, everything back to zero.
        arm_overflow();
        expect_read("rstovf_pre", TIMA_A, 8'hFF, 1'b0);
        expect_read("rstovf_ovf", TIMA_A, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_read($sformatf("rstovf_%0d", i), TIMA_A, 8'h00, 1'b0);
        end
        expect_read("rstovf_tma", TMA_A, 8'h00, 1'b0);
        expect_read("rstovf_tac", TAC_A, 8'hF8, 1'b0);
        expect_read("rstovf_div", DIV_A, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
